// File: rtl/tcp_arb_pkg.sv
// Shared types and constants for the TCP transmit arbiter: packed header layout,
// arbiter FSM encoding and the round-robin pointer helper.
package tcp_arb_pkg;

  localparam int TCP_HDR_W = 428;

  // Header layout, dest_mac occupies the most significant bits, urgent_pointer the least.
  localparam int W_DEST_MAC     = 48;
  localparam int W_SRC_MAC      = 48;
  localparam int W_ETH_TYPE     = 16;
  localparam int W_IP_VERSION   = 4;
  localparam int W_IP_IHL       = 4;
  localparam int W_IP_DSCP      = 6;
  localparam int W_IP_ECN       = 2;
  localparam int W_IP_LENGTH    = 16;
  localparam int W_IP_IDENT     = 16;
  localparam int W_IP_FLAGS     = 3;
  localparam int W_IP_FRAG_OFF  = 13;
  localparam int W_IP_TTL       = 8;
  localparam int W_IP_PROTOCOL  = 8;
  localparam int W_IP_CHECKSUM  = 16;
  localparam int W_IP_SRC       = 32;
  localparam int W_IP_DEST      = 32;
  localparam int W_SRC_PORT     = 16;
  localparam int W_DEST_PORT    = 16;
  localparam int W_SEQ_NUM      = 32;
  localparam int W_ACK_NUM      = 32;
  localparam int W_DATA_OFFSET  = 4;
  localparam int W_TCP_FLAGS    = 8;
  localparam int W_WINDOW       = 16;
  localparam int W_TCP_CHECKSUM = 16;
  localparam int W_URGENT_PTR   = 16;

  localparam int O_URGENT_PTR   = 0;
  localparam int O_TCP_CHECKSUM = O_URGENT_PTR   + W_URGENT_PTR;
  localparam int O_WINDOW       = O_TCP_CHECKSUM + W_TCP_CHECKSUM;
  localparam int O_TCP_FLAGS    = O_WINDOW       + W_WINDOW;
  localparam int O_DATA_OFFSET  = O_TCP_FLAGS    + W_TCP_FLAGS;
  localparam int O_ACK_NUM      = O_DATA_OFFSET  + W_DATA_OFFSET;
  localparam int O_SEQ_NUM      = O_ACK_NUM      + W_ACK_NUM;
  localparam int O_DEST_PORT    = O_SEQ_NUM      + W_SEQ_NUM;
  localparam int O_SRC_PORT     = O_DEST_PORT    + W_DEST_PORT;
  localparam int O_IP_DEST      = O_SRC_PORT     + W_SRC_PORT;
  localparam int O_IP_SRC       = O_IP_DEST      + W_IP_DEST;
  localparam int O_IP_CHECKSUM  = O_IP_SRC       + W_IP_SRC;
  localparam int O_IP_PROTOCOL  = O_IP_CHECKSUM  + W_IP_CHECKSUM;
  localparam int O_IP_TTL       = O_IP_PROTOCOL  + W_IP_PROTOCOL;
  localparam int O_IP_FRAG_OFF  = O_IP_TTL       + W_IP_TTL;
  localparam int O_IP_FLAGS     = O_IP_FRAG_OFF  + W_IP_FRAG_OFF;
  localparam int O_IP_IDENT     = O_IP_FLAGS     + W_IP_FLAGS;
  localparam int O_IP_LENGTH    = O_IP_IDENT     + W_IP_IDENT;
  localparam int O_IP_ECN       = O_IP_LENGTH    + W_IP_LENGTH;
  localparam int O_IP_DSCP      = O_IP_ECN       + W_IP_ECN;
  localparam int O_IP_IHL       = O_IP_DSCP      + W_IP_DSCP;
  localparam int O_IP_VERSION   = O_IP_IHL       + W_IP_IHL;
  localparam int O_ETH_TYPE     = O_IP_VERSION   + W_IP_VERSION;
  localparam int O_SRC_MAC      = O_ETH_TYPE     + W_ETH_TYPE;
  localparam int O_DEST_MAC     = O_SRC_MAC      + W_SRC_MAC;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_HDR     = 2'b01,
    ARB_PAYLOAD = 2'b10
  } arb_state_t;

  // Requester index that gets first priority after requester g finishes.
  function automatic int rr_next(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/tcp_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above i_ptr,
// wrapping modulo N.
module tcp_rr_pick
  import tcp_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!o_found && i_req[(int'(i_ptr) + k) % N]) begin
        o_found = 1'b1;
        o_idx   = IW'((int'(i_ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/tcp_tx_arbiter.sv
// Round-robin arbiter muxing N header+payload TCP transmit streams onto one output;
// ownership is held from header grant until the payload tlast handshake.
module tcp_tx_arbiter
  import tcp_arb_pkg::*;
#(
  parameter  int N      = 4,
  parameter  int DATA_W = 64,
  localparam int KEEP_W = DATA_W / 8,
  localparam int IW     = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           s_hdr_valid,
  output logic [N-1:0]           s_hdr_ready,
  input  logic [N*TCP_HDR_W-1:0] s_hdr_data,
  input  logic [N*DATA_W-1:0]    s_payload_tdata,
  input  logic [N*KEEP_W-1:0]    s_payload_tkeep,
  input  logic [N-1:0]           s_payload_tvalid,
  input  logic [N-1:0]           s_payload_tlast,
  input  logic [N-1:0]           s_payload_tuser,
  output logic [N-1:0]           s_payload_tready,
  output logic                   m_hdr_valid,
  input  logic                   m_hdr_ready,
  output logic [TCP_HDR_W-1:0]   m_hdr_data,
  output logic [DATA_W-1:0]      m_payload_tdata,
  output logic [KEEP_W-1:0]      m_payload_tkeep,
  output logic                   m_payload_tvalid,
  output logic                   m_payload_tlast,
  output logic                   m_payload_tuser,
  input  logic                   m_payload_tready,
  output logic [IW-1:0]          grant_idx,
  output logic                   busy
);

  arb_state_t    r_state;
  logic [IW-1:0] r_grant;
  logic [IW-1:0] r_ptr;
  logic          r_busy;

  logic [IW-1:0] w_pick_idx;
  logic          w_pick_found;
  logic          w_hdr_hs;
  logic          w_last_hs;

  tcp_rr_pick #(.N(N)) u_pick (
    .i_req   (s_hdr_valid),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  assign w_hdr_hs  = (r_state == ARB_HDR) && s_hdr_valid[r_grant] && m_hdr_ready;
  assign w_last_hs = (r_state == ARB_PAYLOAD) && s_payload_tvalid[r_grant]
                     && s_payload_tlast[r_grant] && m_payload_tready;

  // Control: owner selection and frame sequencing
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_found) begin
            r_grant <= w_pick_idx;
            r_state <= ARB_HDR;
            r_busy  <= 1'b1;
          end
        end
        ARB_HDR: begin
          // A requester that drops its header valid keeps ownership; no regrant.
          if (w_hdr_hs) begin
            r_state <= ARB_PAYLOAD;
          end
        end
        ARB_PAYLOAD: begin
          if (w_last_hs) begin
            r_state <= ARB_IDLE;
            r_busy  <= 1'b0;
            r_ptr   <= IW'(rr_next(int'(r_grant), N));
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: zero-latency mux from the owning requester
  always_comb begin
    m_hdr_data       = s_hdr_data[int'(r_grant)*TCP_HDR_W +: TCP_HDR_W];
    m_payload_tdata  = s_payload_tdata[int'(r_grant)*DATA_W +: DATA_W];
    m_payload_tkeep  = s_payload_tkeep[int'(r_grant)*KEEP_W +: KEEP_W];
    m_payload_tlast  = s_payload_tlast[r_grant];
    m_payload_tuser  = s_payload_tuser[r_grant];
    m_hdr_valid      = 1'b0;
    m_payload_tvalid = 1'b0;
    s_hdr_ready      = '0;
    s_payload_tready = '0;
    if (r_state == ARB_HDR) begin
      m_hdr_valid          = s_hdr_valid[r_grant];
      s_hdr_ready[r_grant] = m_hdr_ready;
    end
    if (r_state == ARB_PAYLOAD) begin
      m_payload_tvalid          = s_payload_tvalid[r_grant];
      s_payload_tready[r_grant] = m_payload_tready;
    end
  end

  assign grant_idx = r_grant;
  assign busy      = r_busy;

endmodule
